alien_formation_ctrl: RTL
=========================

Name: alien_formation_ctrl

Overview:
Sequences the 15-alien formation (3 rows x 5 columns) that feeds the colour mapper's AlienX/AlienY arrays. Once per video frame it steps the formation, reversing and descending at the screen edges. It then scans all aliens against the player missile, kills at most one alien, and reports hit, score, wave-clear and game-over to the game top level. Dead aliens are parked off-screen, so the mapper needs no alive input.

Parameters:
ORIGIN_X0, 64, formation origin X at reset and at wave restart
ORIGIN_Y0, 40, formation origin Y at reset and at wave restart
SPACING_X, 48, column pitch in pixels
SPACING_Y, 40, row pitch in pixels
ALIEN_W, 31, alien size X; same inclusive-extent meaning as Alien_sizeX
ALIEN_H, 23, alien size Y; same inclusive-extent meaning as Alien_sizeY
STEP_X, 2, horizontal pixels moved per frame
DROP_Y, 16, descent in pixels on each edge bounce
X_MIN, 0, left screen bound
X_MAX, 639, right screen bound
GROUND_Y, 400, game over when any alive alien's bottom edge reaches this row

Ports:
Clk  in  1  system clock; the only clock
Reset  in  1  synchronous, active-high
frame_clk  in  1  vsync-rate level, sampled on Clk; its rising edge is the frame tick
missile_active  in  1  missile in flight
MissileX, MissileY  in  10 each  missile top-left
Missile_sizeX, Missile_sizeY  in  10 each  missile extent
AlienX[15], AlienY[15]  out  10 each  alien top-left; index = row*5 + col
Alien_sizeX[15], Alien_sizeY[15]  out  10 each  constant ALIEN_W / ALIEN_H
alive  out  15  bit i is set while alien i lives
hit  out  1  one-cycle pulse when an alien is killed
hit_idx  out  4  index of the killed alien; holds until the next hit
score  out  16  accumulated score
wave_clear  out  1  level; high in state CLEAR
game_over  out  1  level; high in state OVER

Behaviour:
- Reset (synchronous, checked before any state logic; also valid mid-scan):
  - origin = (ORIGIN_X0, ORIGIN_Y0), dir = right, alive = all ones, score = 0
  - hit = 0, hit_idx = 0, scan idx = 0, state = WAIT
  - frame_clk edge-detect register cleared
- Frame tick: register frame_clk; tick = frame_clk & ~frame_clk_q. Ticks arriving outside WAIT, CLEAR or OVER are dropped.
- Position outputs (registered from origin and alive):
  - alive alien i: AlienX = originX + (i%5)*SPACING_X; AlienY = originY + (i/5)*SPACING_Y
  - dead alien: AlienX = AlienY = 10'h3FF
- States:
  - WAIT: on tick go to MOVE.
  - MOVE (1 cycle):
    - Lc / Rc = leftmost / rightmost column containing any alive alien.
    - dir right: if originX + Rc*SPACING_X + ALIEN_W + STEP_X > X_MAX, set dir = left and originY += DROP_Y (no X step this frame); else originX += STEP_X.
    - dir left: if originX + Lc*SPACING_X < X_MIN + STEP_X, set dir = right and originY += DROP_Y; else originX -= STEP_X.
    - All arithmetic is done at 11 bits so no wrap occurs.
    - Next state CHECK.
  - CHECK (1 cycle):
    - Br = lowest row containing any alive alien.
    - If new originY + Br*SPACING_Y + ALIEN_H >= GROUND_Y, go to OVER.
    - Else go to SCAN if missile_active, otherwise WAIT.
  - SCAN (one alien per cycle, idx 0..14):
    - Test alive[idx] and overlap of the idx alien box with the missile box.
    - Both boxes are inclusive extents, matching the mapper: [x, x+size].
    - Overlap when Ax <= Mx+MsX and Mx <= Ax+ALIEN_W, and the same condition in Y.
    - On the first overlapping alive alien:
      - clear alive[idx], set hit = 1 and hit_idx = idx
      - score += 30 / 20 / 10 for row 0 / 1 / 2, saturating at 65535
      - go to DONE
    - At most one kill per frame.
    - If idx reaches 14 with no hit, go to DONE.
    - SCAN lasts at most 15 cycles.
  - DONE (1 cycle): hit returns to 0; idx = 0. Go to CLEAR if alive == 0, else WAIT.
  - CLEAR: wave_clear = 1. On tick: alive = all ones, origin reset, dir = right, score kept; go to WAIT.
  - OVER: game_over = 1; all positions frozen; leave only by Reset.
- Registered outputs update the cycle after the state registers. Tick-to-hit latency is at most 18 Clk cycles.

Test Plan:
1. Reset, then one tick → AlienX[0] = 66, AlienY[0] = 40; AlienX[14] = 66+192 = 258, AlienY[14] = 120; alive = 15'h7FFF; hit = 0.
2. Origin 413 moving right with column 4 alive: (413+192+31+2 = 638, in bound) → originX = 415. Next tick: 415+192+31+2 = 640 > 639 → dir = left, originY += 16, originX unchanged.
3. Missile at (AlienX[7], AlienY[7]+23), size 3x8, active → exactly one hit pulse; hit_idx = 7; alive[7] = 0; score = 20; AlienX[7] = 3FF.
4. Missile box overlapping aliens 0 and 1 → only alien 0 killed this frame; alien 1 killed on the next tick.
5. Kill aliens one by one until alive = 0 → wave_clear = 1; next tick restores alive = 7FFF and origin (64,40); score preserved.
6. Force descent until bottom row reaches GROUND_Y → game_over = 1, positions frozen across further ticks. Reset asserted mid-SCAN → all reset values on the next cycle.

Source files
------------

// File: rtl/alien_formation_ctrl.sv
// rtl/alien_formation_ctrl.sv - 3x5 alien formation stepper with missile hit scan and scoring
// Once per frame: step/bounce the formation, check the ground, then scan one alien per cycle.
module alien_formation_ctrl #(
  parameter int ORIGIN_X0 = 64,
  parameter int ORIGIN_Y0 = 40,
  parameter int SPACING_X = 48,
  parameter int SPACING_Y = 40,
  parameter int ALIEN_W   = 31,
  parameter int ALIEN_H   = 23,
  parameter int STEP_X    = 2,
  parameter int DROP_Y    = 16,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int GROUND_Y  = 400
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        missile_active,
  input  logic [9:0]  MissileX,
  input  logic [9:0]  MissileY,
  input  logic [9:0]  Missile_sizeX,
  input  logic [9:0]  Missile_sizeY,
  output logic [9:0]  AlienX      [15],
  output logic [9:0]  AlienY      [15],
  output logic [9:0]  Alien_sizeX [15],
  output logic [9:0]  Alien_sizeY [15],
  output logic [14:0] alive,
  output logic        hit,
  output logic [3:0]  hit_idx,
  output logic [15:0] score,
  output logic        wave_clear,
  output logic        game_over
);

  typedef enum logic [2:0] {S_WAIT, S_MOVE, S_CHECK, S_SCAN, S_DONE, S_CLEAR, S_OVER} state_t;

  state_t      state;
  logic [9:0]  origin_x;
  logic [9:0]  origin_y;
  logic        dir_left;
  logic [3:0]  idx;
  logic        frame_q;
  logic        tick;

  logic [4:0]  col_any;
  logic [2:0]  lc;
  logic [2:0]  rc;
  logic [1:0]  br;
  logic [10:0] ox;
  logic [10:0] oy;
  logic [10:0] right_edge;
  logic [10:0] left_edge;
  logic [10:0] bottom;
  logic [2:0]  scol;
  logic [1:0]  srow;
  logic [10:0] ax;
  logic [10:0] ay;
  logic [10:0] mx;
  logic [10:0] my;
  logic [10:0] mx_end;
  logic [10:0] my_end;
  logic        overlap;
  logic [4:0]  pts;
  logic [16:0] score_sum;

  assign tick = frame_clk & ~frame_q;
  assign ox   = {1'b0, origin_x};
  assign oy   = {1'b0, origin_y};

  // Extents of the surviving formation decide where the edges and the ground are.
  always_comb begin
    col_any = '0;
    lc      = 3'd0;
    rc      = 3'd0;
    br      = 2'd0;
    for (int c = 0; c < 5; c++) col_any[c] = alive[c] | alive[c+5] | alive[c+10];
    for (int c = 4; c >= 0; c--) if (col_any[c]) lc = 3'(c);
    for (int c = 0; c < 5; c++) if (col_any[c]) rc = 3'(c);
    for (int r = 0; r < 3; r++) if (|alive[r*5 +: 5]) br = 2'(r);
  end

  assign right_edge = ox + 11'(rc) * 11'(SPACING_X) + 11'(ALIEN_W + STEP_X);
  assign left_edge  = ox + 11'(lc) * 11'(SPACING_X);
  assign bottom     = oy + 11'(br) * 11'(SPACING_Y) + 11'(ALIEN_H);

  always_comb begin
    srow = 2'd0;
    scol = 3'(idx);
    if (idx >= 4'd10) begin
      srow = 2'd2;
      scol = 3'(idx - 4'd10);
    end else if (idx >= 4'd5) begin
      srow = 2'd1;
      scol = 3'(idx - 4'd5);
    end
  end

  // Both boxes use inclusive extents [x, x+size], matching the colour mapper.
  assign ax        = ox + 11'(scol) * 11'(SPACING_X);
  assign ay        = oy + 11'(srow) * 11'(SPACING_Y);
  assign mx        = {1'b0, MissileX};
  assign my        = {1'b0, MissileY};
  assign mx_end    = mx + {1'b0, Missile_sizeX};
  assign my_end    = my + {1'b0, Missile_sizeY};
  assign overlap   = (ax <= mx_end) && (mx <= ax + 11'(ALIEN_W)) &&
                     (ay <= my_end) && (my <= ay + 11'(ALIEN_H));
  assign pts       = (srow == 2'd0) ? 5'd30 : (srow == 2'd1) ? 5'd20 : 5'd10;
  assign score_sum = {1'b0, score} + 17'(pts);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_WAIT;
      origin_x   <= 10'(ORIGIN_X0);
      origin_y   <= 10'(ORIGIN_Y0);
      dir_left   <= 1'b0;
      alive      <= '1;
      score      <= '0;
      hit        <= 1'b0;
      hit_idx    <= '0;
      idx        <= '0;
      frame_q    <= 1'b0;
      wave_clear <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      case (state)
        S_WAIT: if (tick) state <= S_MOVE;
        S_MOVE: begin
          if (!dir_left) begin
            if (right_edge > 11'(X_MAX)) begin
              dir_left <= 1'b1;
              origin_y <= origin_y + 10'(DROP_Y);
            end else begin
              origin_x <= origin_x + 10'(STEP_X);
            end
          end else begin
            if (left_edge < 11'(X_MIN + STEP_X)) begin
              dir_left <= 1'b0;
              origin_y <= origin_y + 10'(DROP_Y);
            end else begin
              origin_x <= origin_x - 10'(STEP_X);
            end
          end
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (bottom >= 11'(GROUND_Y)) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end else if (missile_active) begin
            state <= S_SCAN;
          end else begin
            state <= S_WAIT;
          end
        end
        S_SCAN: begin
          if (alive[idx] && overlap) begin
            alive[idx] <= 1'b0;
            hit        <= 1'b1;
            hit_idx    <= idx;
            score      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            state      <= S_DONE;
          end else if (idx == 4'd14) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_DONE: begin
          hit <= 1'b0;
          idx <= '0;
          if (alive == '0) begin
            state      <= S_CLEAR;
            wave_clear <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_CLEAR: begin
          if (tick) begin
            alive      <= '1;
            origin_x   <= 10'(ORIGIN_X0);
            origin_y   <= 10'(ORIGIN_Y0);
            dir_left   <= 1'b0;
            wave_clear <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_OVER:  state <= S_OVER;
        default: state <= S_WAIT;
      endcase
    end
  end

  // Dead aliens are parked at 3FF so the mapper never draws them.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 15; i++) begin
      if (Reset) begin
        AlienX[i] <= 10'(ORIGIN_X0 + (i % 5) * SPACING_X);
        AlienY[i] <= 10'(ORIGIN_Y0 + (i / 5) * SPACING_Y);
      end else if (alive[i]) begin
        AlienX[i] <= origin_x + 10'((i % 5) * SPACING_X);
        AlienY[i] <= origin_y + 10'((i / 5) * SPACING_Y);
      end else begin
        AlienX[i] <= 10'h3FF;
        AlienY[i] <= 10'h3FF;
      end
    end
  end

  for (genvar g = 0; g < 15; g++) begin : g_size
    assign Alien_sizeX[g] = 10'(ALIEN_W);
    assign Alien_sizeY[g] = 10'(ALIEN_H);
  end

endmodule
